// File: rtl/nx_node_loader_if.sv
// nx_node_loader_if
//   Bundles the three handshake channels of the node loader:
//     command channel : i_cmd_* / i_cmd_valid -> o_cmd_ready
//     word channel    : i_word_data / i_word_valid -> o_word_ready
//     message channel : o_msg_data / o_msg_valid -> i_msg_ready
//   slave  : the loader's view (consumes commands/words, produces messages)
//   master : the host/driver view (produces commands/words, consumes messages)
interface nx_node_loader_if #(
    parameter int unsigned RAM_ADDR_W       = 10,
    parameter int unsigned RAM_DATA_W       = 32,
    parameter int unsigned COUNT_W          = 11,
    parameter int unsigned ROW_W            = 4,
    parameter int unsigned COL_W            = 4,
    parameter int unsigned NODE_PARAM_WIDTH = 8,
    parameter int unsigned MESSAGE_WIDTH    = 64
);
    logic [ROW_W-1:0]            i_cmd_row;
    logic [COL_W-1:0]            i_cmd_column;
    logic [RAM_ADDR_W-1:0]       i_cmd_base;
    logic [COUNT_W-1:0]          i_cmd_count;
    logic [NODE_PARAM_WIDTH-1:0] i_cmd_num_instr;
    logic [NODE_PARAM_WIDTH-1:0] i_cmd_num_output;
    logic                        i_cmd_valid;
    logic                        o_cmd_ready;

    logic [RAM_DATA_W-1:0]       i_word_data;
    logic                        i_word_valid;
    logic                        o_word_ready;

    logic [MESSAGE_WIDTH-1:0]    o_msg_data;
    logic                        o_msg_valid;
    logic                        i_msg_ready;

    modport slave (
        input  i_cmd_row, i_cmd_column, i_cmd_base, i_cmd_count,
        input  i_cmd_num_instr, i_cmd_num_output, i_cmd_valid,
        output o_cmd_ready,
        input  i_word_data, i_word_valid,
        output o_word_ready,
        output o_msg_data, o_msg_valid,
        input  i_msg_ready
    );

    modport master (
        output i_cmd_row, i_cmd_column, i_cmd_base, i_cmd_count,
        output i_cmd_num_instr, i_cmd_num_output, i_cmd_valid,
        input  o_cmd_ready,
        output i_word_data, i_word_valid,
        input  o_word_ready,
        input  o_msg_data, o_msg_valid,
        output i_msg_ready
    );
endinterface

// File: rtl/nx_node_loader.sv
// nx_node_loader
//   Host-side generator of node inbound messages. Accepts a load command and
//   a stream of RAM words, emits one LOAD message per SLOT_W-bit slice of each
//   word (address = base + word index, wrapping), then one CONTROL message
//   carrying num_instr / num_output.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-low reset
//   o_idle : IDLE, output register empty and no command offered
//   bus    : nx_node_loader_if.slave (command, word and message channels)
// Message layout (MSB first):
//   [row | column | command(4) | payload]
//   LOAD payload    : address[ADDR_LSB +: RAM_ADDR_W], slot[SLOT_W +: 8], data[0 +: SLOT_W]
//   CONTROL payload : num_output[NODE_PARAM_WIDTH +: NODE_PARAM_WIDTH], num_instr[0 +: NODE_PARAM_WIDTH]
module nx_node_loader #(
    parameter int unsigned RAM_ADDR_W       = 10,
    parameter int unsigned RAM_DATA_W       = 32,
    parameter int unsigned SLOT_W           = 16,
    parameter int unsigned COUNT_W          = 11,
    parameter int unsigned ROW_W            = 4,
    parameter int unsigned COL_W            = 4,
    parameter int unsigned NODE_PARAM_WIDTH = 8,
    parameter int unsigned MESSAGE_WIDTH    = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_idle,
    nx_node_loader_if.slave  bus
);
    localparam int unsigned SLOTS      = RAM_DATA_W / SLOT_W;
    localparam int unsigned SLOT_IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned MSG_SLOT_W = 8;
    localparam int unsigned CMD_W      = 4;
    localparam int unsigned ROW_LSB    = MESSAGE_WIDTH - ROW_W;
    localparam int unsigned COL_LSB    = ROW_LSB - COL_W;
    localparam int unsigned CMD_LSB    = COL_LSB - CMD_W;
    localparam int unsigned SLOT_LSB   = SLOT_W;
    localparam int unsigned ADDR_LSB   = SLOT_W + MSG_SLOT_W;

    localparam logic [CMD_W-1:0] NODE_COMMAND_LOAD    = 4'd1;
    localparam logic [CMD_W-1:0] NODE_COMMAND_CONTROL = 4'd2;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CTRL, S_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [RAM_ADDR_W-1:0]       base_q, base_d;
    logic [COUNT_W-1:0]          count_q, count_d;
    logic [NODE_PARAM_WIDTH-1:0] instr_q, instr_d;
    logic [NODE_PARAM_WIDTH-1:0] nout_q, nout_d;
    logic [COUNT_W-1:0]          wcnt_q, wcnt_d;
    logic [SLOT_IDX_W-1:0]       slot_q, slot_d;
    logic [RAM_DATA_W-1:0]       word_q, word_d;
    logic [MESSAGE_WIDTH-1:0]    msg_data_q, msg_data_d;
    logic                        msg_valid_q, msg_valid_d;

    logic                          cmd_ready;
    logic                          word_ready;
    logic                          can_load;
    logic [COUNT_W-1:0]            wcnt_inc;
    logic [RAM_ADDR_W-1:0]         load_addr;
    logic [SLOTS-1:0][SLOT_W-1:0]  word_slots;
    logic [MESSAGE_WIDTH-1:0]      load_msg;
    logic [MESSAGE_WIDTH-1:0]      ctrl_msg;

    assign word_slots = word_q;
    assign wcnt_inc   = wcnt_q + COUNT_W'(1);
    assign load_addr  = base_q + wcnt_q[RAM_ADDR_W-1:0];
    // Output register may take a new value when empty or being handshaken now.
    assign can_load   = !msg_valid_q || bus.i_msg_ready;

    always_comb begin
        load_msg = '0;
        load_msg[ROW_LSB +: ROW_W]         = row_q;
        load_msg[COL_LSB +: COL_W]         = col_q;
        load_msg[CMD_LSB +: CMD_W]         = NODE_COMMAND_LOAD;
        load_msg[ADDR_LSB +: RAM_ADDR_W]   = load_addr;
        load_msg[SLOT_LSB +: MSG_SLOT_W]   = MSG_SLOT_W'(slot_q);
        load_msg[0 +: SLOT_W]              = word_slots[slot_q];

        ctrl_msg = '0;
        ctrl_msg[ROW_LSB +: ROW_W]                       = row_q;
        ctrl_msg[COL_LSB +: COL_W]                       = col_q;
        ctrl_msg[CMD_LSB +: CMD_W]                       = NODE_COMMAND_CONTROL;
        ctrl_msg[NODE_PARAM_WIDTH +: NODE_PARAM_WIDTH]   = nout_q;
        ctrl_msg[0 +: NODE_PARAM_WIDTH]                  = instr_q;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        base_d      = base_q;
        count_d     = count_q;
        instr_d     = instr_q;
        nout_d      = nout_q;
        wcnt_d      = wcnt_q;
        slot_d      = slot_q;
        word_d      = word_q;
        msg_data_d  = msg_data_q;
        msg_valid_d = msg_valid_q && !bus.i_msg_ready;
        cmd_ready   = 1'b0;
        word_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.i_cmd_valid) begin
                    row_d   = bus.i_cmd_row;
                    col_d   = bus.i_cmd_column;
                    base_d  = bus.i_cmd_base;
                    count_d = bus.i_cmd_count;
                    instr_d = bus.i_cmd_num_instr;
                    nout_d  = bus.i_cmd_num_output;
                    wcnt_d  = '0;
                    slot_d  = '0;
                    state_d = (bus.i_cmd_count != '0) ? S_FETCH : S_CTRL;
                end
            end
            S_FETCH: begin
                word_ready = can_load;
                if (can_load && bus.i_word_valid) begin
                    word_d  = bus.i_word_data;
                    slot_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (can_load) begin
                    msg_data_d  = load_msg;
                    msg_valid_d = 1'b1;
                    if (slot_q == SLOT_IDX_W'(SLOTS - 1)) begin
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc == count_q) begin
                            state_d = S_CTRL;
                        end else begin
                            // Fetch the next word alongside the last slot so
                            // word boundaries cost no bubble.
                            word_ready = 1'b1;
                            if (bus.i_word_valid) begin
                                word_d = bus.i_word_data;
                                slot_d = '0;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    end else begin
                        slot_d = slot_q + SLOT_IDX_W'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_CTRL: begin
                if (can_load) begin
                    msg_data_d  = ctrl_msg;
                    msg_valid_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Register holds until handshaken; the command field tells
                // whether the held message ends the transfer.
                if (bus.i_msg_ready) begin
                    state_d = (msg_data_q[CMD_LSB +: CMD_W] == NODE_COMMAND_CONTROL) ?
                              S_IDLE : S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            base_q      <= '0;
            count_q     <= '0;
            instr_q     <= '0;
            nout_q      <= '0;
            wcnt_q      <= '0;
            slot_q      <= '0;
            word_q      <= '0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            count_q     <= count_d;
            instr_q     <= instr_d;
            nout_q      <= nout_d;
            wcnt_q      <= wcnt_d;
            slot_q      <= slot_d;
            word_q      <= word_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
        end
    end

    assign bus.o_cmd_ready  = cmd_ready && i_rst;
    assign bus.o_word_ready = word_ready;
    assign bus.o_msg_data   = msg_data_q;
    assign bus.o_msg_valid  = msg_valid_q;
    assign o_idle           = (state_q == S_IDLE) && !msg_valid_q && !bus.i_cmd_valid;
endmodule

// File: doc/nx_node_loader.md
Name: nx_node_loader

Overview:
- Host-side message generator: the transmit end of the node inbound message protocol that nx_node_decoder consumes.
- Accepts a load command plus a stream of RAM words, serialises them into node_message_t load messages addressed to one node, then emits one control message carrying the instruction and output counts.
- Sits at the mesh edge, driving one inbound port of the corner node.

Parameters:
- RAM_ADDR_W, 10, node RAM address width.
- RAM_DATA_W, 32, node RAM word width.
- SLOT_W, 16, data bits per load message; RAM_DATA_W must be a multiple of SLOT_W; SLOTS = RAM_DATA_W/SLOT_W.
- COUNT_W, 11, width of word count (RAM_ADDR_W+1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- o_idle  out  1  high in IDLE with no command pending.
- i_cmd_row  in  node_id_t.row width  target node row.
- i_cmd_column  in  node_id_t.column width  target node column.
- i_cmd_base  in  RAM_ADDR_W  first RAM address.
- i_cmd_count  in  COUNT_W  number of RAM words to load (0 allowed).
- i_cmd_num_instr  in  NODE_PARAM_WIDTH  control message num_instr.
- i_cmd_num_output  in  NODE_PARAM_WIDTH  control message num_output.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when valid && ready.
- i_word_data  in  RAM_DATA_W  RAM word.
- i_word_valid  in  1  word valid.
- o_word_ready  out  1  word consumed when valid && ready.
- o_msg_data  out  MESSAGE_WIDTH  outbound node_message_t.
- o_msg_valid  out  1  message valid.
- i_msg_ready  in  1  downstream ready.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE, o_msg_valid=0, o_msg_data=0, o_cmd_ready=0, o_word_ready=0, o_idle=1, all counters 0. Reset asserted mid-transfer aborts immediately; the partial load is not resumed.
- FSM states: IDLE, FETCH, SEND, CTRL, DRAIN.
- IDLE:
  - o_cmd_ready=1.
  - On accept, latch row, column, base, count and params; word counter=0.
  - Go to FETCH if count>0, else CTRL.
- FETCH:
  - o_word_ready=1 only while the output register is empty or draining (!o_msg_valid || i_msg_ready).
  - On accept, latch the word, slot=0, go to SEND.
- SEND:
  - Load the output register with a LOAD message: header.row/column=latched target, header.command=NODE_COMMAND_LOAD, payload address=base+word counter (modulo 2^RAM_ADDR_W, wraps silently), payload slot=slot index, payload data=word[slot*SLOT_W +: SLOT_W], all other bits 0.
  - Advance the slot on each message handshake.
  - After slot SLOTS-1 is handshaken, increment the word counter. If the counter equals count, go to CTRL; otherwise go to FETCH.
- CTRL:
  - Emit a CONTROL message: command=NODE_COMMAND_CONTROL, num_instr and num_output from the latched values, other bits 0.
  - On handshake go to IDLE.
- DRAIN: entered only when a register update is blocked. The output register holds its value (o_msg_data and o_msg_valid stable) while o_msg_valid && !i_msg_ready; no field may change until the handshake.
- Latency:
  - Command accept to the first message valid: 2 cycles (FETCH word accept, then register load), given the word is already valid.
  - Back-to-back messages: 1 per cycle when i_msg_ready is held high, including across word boundaries; the next word fetch overlaps the final slot handshake.
- A new command is not accepted until the CTRL message handshake completes; o_cmd_ready=0 outside IDLE.
- i_word_valid low mid-transfer: o_msg_valid drops after the current message is accepted; there is no bubble-filling with stale data.
- Words offered while the block is in IDLE are not consumed.
- o_idle = (state==IDLE) && !o_msg_valid && !i_cmd_valid.

Test Plan:
- Single word: cmd row=1 col=2 base=0x010 count=1 instr=5 out=3, word 0xDEADBEEF, ready held high → 3 messages: LOAD addr 0x010 slot0 data 0xBEEF; LOAD addr 0x010 slot1 data 0xDEAD; CONTROL num_instr=5 num_output=3; o_idle returns to 1.
- Zero count: count=0, instr=0, out=0 → exactly one CONTROL message; o_word_ready never asserted.
- Backpressure: count=4 with random i_msg_ready at 30% duty → 8 LOAD messages, addresses base..base+3, each field stable while stalled, no loss or duplication versus a scoreboard.
- Address wrap: base=0x3FF count=2 → addresses 0x3FF then 0x000.
- Word starvation: i_word_valid low for 10 cycles between words → o_msg_valid low during the gap; sequence otherwise identical to the unstalled case.
- Reset mid-transfer: pull i_rst low after 3 messages → all outputs 0 asynchronously, o_idle=1; a following command runs cleanly from slot 0.
